// File: rtl/kalman_pkg.sv
// kalman_pkg: shared measurement-path types and constants
// Provides MEAS_DIM, the fp64_t element type and the read/write FSM state enums.
package kalman_pkg;
  localparam int MEAS_DIM = 6;
  typedef logic [63:0] fp64_t;
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} rd_state_t;
  typedef enum logic {FILL, DRAIN} wr_state_t;
endpackage

// File: rtl/meas_bank.sv
// meas_bank: one MEAS_DIM x VEC_WIDTH frame bank with a full flag
// Ports: clk, rst_n (async active-low); we/idx/din write one element;
// set/clr raise/drop the full flag; data is the whole bank, full the flag.
module meas_bank #(
  parameter int VEC_WIDTH = 64,
  parameter int MEAS_DIM  = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [$clog2(MEAS_DIM)-1:0]         idx,
  input  logic [VEC_WIDTH-1:0]                din,
  input  logic                                set,
  input  logic                                clr,
  output logic [MEAS_DIM-1:0][VEC_WIDTH-1:0]  data,
  output logic                                full
);
  import kalman_pkg::*;
  always_ff @(posedge clk)
    if (we) data[idx] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) full <= 1'b0;
    else if (set) full <= 1'b1;
    else if (clr) full <= 1'b0;
endmodule

// File: rtl/meas_frame_buffer.sv
// meas_frame_buffer: frames a serial measurement stream into double-buffered Z_k vectors
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_data/s_last element stream;
// Z_k/Init_Valid held frame to the predictor, SP_DONE retires it;
// frame_err pulses per discarded frame, drop_cnt saturates.
// Build option MEAS_NAN_CHECK_EN: discard frames holding any NaN/Inf element.
module meas_frame_buffer #(
  parameter int VEC_WIDTH = 64,
  parameter int MEAS_DIM  = kalman_pkg::MEAS_DIM,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [VEC_WIDTH-1:0]                s_data,
  input  logic                                s_last,
  output logic [MEAS_DIM-1:0][VEC_WIDTH-1:0]  Z_k,
  output logic                                Init_Valid,
  input  logic                                SP_DONE,
  output logic                                frame_err,
  output logic [CNT_WIDTH-1:0]                drop_cnt
);
  import kalman_pkg::*;
  localparam int IW = $clog2(MEAS_DIM);
  localparam logic [IW-1:0] LAST = IW'(MEAS_DIM - 1);
  rd_state_t rd_st;
  wr_state_t wr_st;
  logic wptr, rptr, acc, fill_acc, at_end, bad, commit, drop, rel;
  logic [IW-1:0] wcnt;
  logic [1:0] full;
  logic [MEAS_DIM-1:0][VEC_WIDTH-1:0] bank_q [2];
  // DRAIN must keep swallowing an overlong frame even while both banks are full
  assign s_ready  = !full[wptr] || wr_st == DRAIN;
  assign acc      = s_valid && s_ready;
  assign fill_acc = acc && wr_st == FILL;
  assign at_end   = wcnt == LAST;
`ifdef MEAS_NAN_CHECK_EN
  logic bad_q;
  // exponent all ones marks NaN or Inf; sticky until the frame ends
  assign bad = bad_q || &s_data[VEC_WIDTH-2 -: 11];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bad_q <= 1'b0;
    else if (fill_acc) bad_q <= (s_last || at_end) ? 1'b0 : bad;
`else
  assign bad = 1'b0;
`endif
  assign commit = fill_acc && s_last && at_end && !bad;
  assign drop   = (fill_acc && s_last && (!at_end || bad)) || (acc && wr_st == DRAIN && s_last);
  assign rel    = rd_st == PRESENT && SP_DONE;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    meas_bank #(.VEC_WIDTH(VEC_WIDTH), .MEAS_DIM(MEAS_DIM)) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (fill_acc && wptr == 1'(g)),
      .idx  (wcnt),
      .din  (s_data),
      .set  (commit && wptr == 1'(g)),
      .clr  (rel && rptr == 1'(g)),
      .data (bank_q[g]),
      .full (full[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_st     <= FILL;
      wcnt      <= '0;
      wptr      <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      frame_err <= drop;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (commit) wptr <= !wptr;
      if (fill_acc) begin
        wcnt <= (s_last || at_end) ? '0 : wcnt + 1'b1;
        if (at_end && !s_last) wr_st <= DRAIN;
      end else if (acc && s_last) wr_st <= FILL;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_st      <= IDLE;
      rptr       <= 1'b0;
      Init_Valid <= 1'b0;
      Z_k        <= '0;
    end else begin
      unique case (rd_st)
        IDLE:
          if (full[rptr]) begin
            rd_st      <= PRESENT;
            Init_Valid <= 1'b1;
            Z_k        <= bank_q[rptr];
          end
        PRESENT:
          if (SP_DONE) begin
            rd_st      <= GAP;
            Init_Valid <= 1'b0;
            rptr       <= !rptr;
          end
        GAP: rd_st <= IDLE;
        default: rd_st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_meas_frame_buffer.sv
// tb_meas_frame_buffer: scoreboard bench for meas_frame_buffer
module tb_meas_frame_buffer;
  localparam int VW = 64, MD = 6, CW = 16;
  typedef logic [MD-1:0][VW-1:0] frame_t;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, SP_DONE = 0;
  logic s_ready, Init_Valid, frame_err;
  logic [VW-1:0] s_data = '0;
  frame_t Z_k;
  logic [CW-1:0] drop_cnt;
  int tests = 0, fails = 0, cyc = 0, exp_drops = 0, act_err = 0, last_cyc = 0;
  bit stim_done = 0;
  frame_t exp_q[$];
  logic [63:0] fbuf[10];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  meas_frame_buffer #(.VEC_WIDTH(VW), .MEAS_DIM(MD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .Z_k(Z_k), .Init_Valid(Init_Valid), .SP_DONE(SP_DONE),
    .frame_err(frame_err), .drop_cnt(drop_cnt));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin : monitor
    logic prev;
    frame_t held, e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0;
        act_err = 0;
      end else begin
        if (frame_err) act_err++;
        if (Init_Valid && !prev) begin
          held = Z_k;
          if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            for (int i = 0; i < MD; i++) chk($sformatf("zk[%0d]", i), Z_k[i], e[i]);
          end
        end else if (Init_Valid) chk("zk_stable", {63'd0, Z_k !== held}, 64'd0);
        prev = Init_Valid;
      end
    end
  end
  task automatic send_elem(input logic [63:0] d, input logic l, output bit stalled);
    int b;
    logic rdy;
    b = 0;
    stalled = 0;
    s_valid = 1; s_data = d; s_last = l;
    do begin
      @(negedge clk);
      rdy = s_ready;
      last_cyc = cyc;
      if (!rdy) stalled = 1;
      @(posedge clk); #1;
      b++;
    end while (!rdy && b < 500);
    if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
    s_valid = 0; s_last = 0;
  endtask
  // reference: exactly MD elements (and, with the check, all finite) is a good frame
  task automatic send_frame(input int n, output bit stalled);
    frame_t f;
    bit ok, st;
    f = '0;
    stalled = 0;
    ok = (n == MD);
    for (int i = 0; i < n; i++) begin
      send_elem(fbuf[i], i == n - 1, st);
      stalled |= st;
      if (i < MD) f[i] = fbuf[i];
`ifdef MEAS_NAN_CHECK_EN
      if (fbuf[i][62:52] == 11'h7FF) ok = 0;
`endif
    end
    if (ok) exp_q.push_back(f);
    else exp_drops++;
  endtask
  task automatic fill_seq();
    for (int i = 0; i < 10; i++) fbuf[i] = $realtobits(real'(i + 1));
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 10; i++) fbuf[i] = {$urandom, $urandom};
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_present(input string name, input int lat);
    int b;
    b = 0;
    do begin @(negedge clk); b++; end while (!Init_Valid && b < 200);
    chk({name, "_present"}, {63'd0, Init_Valid}, 64'd1);
    if (lat > 0) chk({name, "_latency"}, 64'(cyc - last_cyc), 64'(lat));
    @(posedge clk); #1;
  endtask
  task automatic pulse_done();
    SP_DONE = 1;
    @(posedge clk); #1;
    SP_DONE = 0;
  endtask
  initial begin : stim
    bit st;
    #3;
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_init_valid", {63'd0, Init_Valid}, 64'd0);
    chk("rst_zk_zero", {63'd0, |Z_k}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    #8 rst_n = 1;
    wait_cyc(2);
    // single frame 1.0 .. 6.0
    fill_seq();
    send_frame(MD, st);
    wait_present("single", 2);
    chk("single_zk0", Z_k[0], 64'h3FF0000000000000);
    wait_cyc(10);
    pulse_done();
    @(negedge clk);
    chk("single_iv_low", {63'd0, Init_Valid}, 64'd0);
    wait_cyc(3);
    // three frames, no SP_DONE until both banks are full
    fill_rand(); send_frame(MD, st);
    wait_present("three_a", 2);
    fill_rand(); send_frame(MD, st);
    @(negedge clk);
    chk("three_ready_low", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    fork
      begin fill_rand(); send_frame(MD, st); end
      begin
        wait_cyc(4);
        chk("three_still_stalled", {63'd0, s_ready}, 64'd0);
        pulse_done();
        @(negedge clk); chk("gap_t1", {63'd0, Init_Valid}, 64'd0);
        @(negedge clk); chk("gap_t2", {63'd0, Init_Valid}, 64'd0);
        @(negedge clk); chk("gap_t3", {63'd0, Init_Valid}, 64'd1);
        @(posedge clk); #1;
      end
    join
    wait_present("three_b", 0);
    pulse_done();
    wait_present("three_c", 0);
    pulse_done();
    wait_cyc(3);
    // short frame, then SP_DONE while idle, then a good frame
    fill_rand(); send_frame(4, st);
    @(negedge clk);
    chk("short_frame_err", {63'd0, frame_err}, 64'd1);
    chk("short_drop_cnt", 64'(drop_cnt), 64'd1);
    repeat (4) @(negedge clk);
    chk("short_no_present", {63'd0, Init_Valid}, 64'd0);
    @(posedge clk); #1;
    pulse_done();
    fill_rand(); send_frame(MD, st);
    wait_present("after_short", 2);
    pulse_done();
    wait_cyc(3);
    // long frame
    fill_rand(); send_frame(8, st);
    chk("long_no_stall", {63'd0, st}, 64'd0);
    @(negedge clk);
    chk("long_frame_err", {63'd0, frame_err}, 64'd1);
    chk("long_drop_cnt", 64'(drop_cnt), 64'd2);
    repeat (5) @(negedge clk);
    chk("long_no_present", {63'd0, Init_Valid}, 64'd0);
    @(posedge clk); #1;
    // non-finite element
    fill_seq();
    fbuf[3] = 64'h7FF8000000000000;
    send_frame(MD, st);
`ifdef MEAS_NAN_CHECK_EN
    @(negedge clk);
    chk("nan_frame_err", {63'd0, frame_err}, 64'd1);
    chk("nan_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    @(posedge clk); #1;
`else
    wait_present("nan_pass", 2);
    pulse_done();
`endif
    wait_cyc(3);
    // reset mid-PRESENT with the other bank also full
    fill_rand(); send_frame(MD, st);
    wait_present("pre_reset", 2);
    fill_rand(); send_frame(MD, st);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_iv", {63'd0, Init_Valid}, 64'd0);
    chk("mid_rst_zk", {63'd0, |Z_k}, 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_ready", {63'd0, s_ready}, 64'd1);
    exp_q.delete();
    exp_drops = 0;
    @(posedge clk); #3 rst_n = 1;
    repeat (5) @(negedge clk);
    chk("no_replay", {63'd0, Init_Valid}, 64'd0);
    @(posedge clk); #1;
    fill_seq(); send_frame(MD, st);
    wait_present("post_reset", 2);
    pulse_done();
    wait_cyc(3);
    // randomized traffic with a randomly slow predictor
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          int n;
          n = ($urandom_range(0, 9) < 7) ? MD : (($urandom_range(0, 1) == 0) ? $urandom_range(1, MD - 1) : $urandom_range(MD + 1, 9));
          fill_rand();
          send_frame(n, st);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        stim_done = 1;
      end
      begin
        int b;
        b = 0;
        while (!(stim_done && exp_q.size() == 0 && !Init_Valid) && b < 20000) begin
          @(negedge clk);
          b++;
          if (Init_Valid) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            @(posedge clk); #1;
            pulse_done();
          end
        end
        if (b >= 20000) chk("random_drain_timeout", 64'd0, 64'd1);
      end
    join
    wait_cyc(4);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_err_pulses", 64'(act_err), 64'(exp_drops));
    chk("final_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
